ht_cmd_ingress: RTL

- Ingress stage placed directly upstream of hash_table_top.
- Buffers host commands in a DEPTH-entry FIFO and drives them onto the hash table's command interface.
- Limits commands in flight inside the table to MAX_INFLIGHT. A command counts as in flight from the moment it is issued until its result handshake completes on the table's result interface.
- Gives back-pressure and occupancy visibility to the host side.

---
 rtl/hash_table_pkg.sv | 24 ++
 rtl/ht_cmd_if.sv | 14 +
 rtl/ht_sc_fifo.sv | 62 ++++++
 rtl/ht_cmd_ingress.sv | 82 ++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared hash table types and system-level sizing defaults.
// The command format is common to every stage that touches the table.
package hash_table;

  localparam int HT_KEY_W = 16;
  localparam int HT_VAL_W = 32;

  localparam int HT_INGRESS_DEPTH = 8;
  localparam int HT_MAX_INFLIGHT  = 16;

  typedef enum logic [1:0] {
    HT_OP_INSERT = 2'd0,
    HT_OP_LOOKUP = 2'd1,
    HT_OP_DELETE = 2'd2,
    HT_OP_NOP    = 2'd3
  } ht_op_t;

  typedef struct packed {
    ht_op_t                op;
    logic [HT_KEY_W-1:0]   key;
    logic [HT_VAL_W-1:0]   value;
  } ht_command_t;

endpackage

// File: rtl/ht_cmd_if.sv
// Command stream into the hash table.
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; once valid rises, cmd stays stable and valid stays high until that transfer.
interface ht_cmd_if;
  import hash_table::*;

  ht_command_t cmd;
  logic        valid;
  logic        ready;

  modport master (output cmd, output valid, input ready);
  modport slave  (input cmd, input valid, output ready);

endinterface

// File: rtl/ht_sc_fifo.sv
// Generic single-clock show-ahead FIFO on a registered memory array.
// Head entry is visible on rdata whenever empty is low; ready is a registered !full.
module ht_sc_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DWIDTH-1:0]       wdata,
  output logic [DWIDTH-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic                    ready,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_ptr_next;
  logic [AW:0]       rd_ptr_next;
  logic              do_push;
  logic              do_pop;
  logic              full_next;

  // The pointer MSB is a wrap bit: equal indices with differing wrap bits mean full.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign wr_ptr_next = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_next = rd_ptr + (AW+1)'(do_pop);
  assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                       (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      ready  <= ~full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ht_cmd_ingress.sv
// Ingress stage ahead of hash_table_top: queues host commands and limits how
// many are outstanding inside the table using a result-driven credit count.
module ht_cmd_ingress
  import hash_table::*;
#(
  parameter int DEPTH        = HT_INGRESS_DEPTH,
  parameter int MAX_INFLIGHT = HT_MAX_INFLIGHT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  ht_cmd_if.slave                        ht_cmd_in,
  ht_cmd_if.master                       ht_cmd_out,
  input  logic                           res_valid_i,
  input  logic                           res_ready_i,
  output logic [$clog2(DEPTH):0]         fifo_level_o,
  output logic [$clog2(MAX_INFLIGHT):0]  inflight_o,
  output logic                           err_underflow_o
);

  localparam int              IW       = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [IW-1:0]   CNT_MAX  = IW'(MAX_INFLIGHT);
  localparam logic [IW-1:0]   CNT_ONE  = IW'(1);

  ht_command_t       head_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              issue;
  logic              retire;
  logic [IW-1:0]     inflight_q;
  logic              err_q;

  assign push   = ht_cmd_in.valid & in_ready & ~fifo_full;
  assign issue  = out_valid & ht_cmd_out.ready;
  assign retire = res_valid_i & res_ready_i;

  ht_sc_fifo #(
    .DWIDTH ($bits(ht_command_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (issue),
    .wdata (ht_cmd_in.cmd),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (in_ready),
    .level (fifo_level_o)
  );

  // Gating uses the registered count, so a freed credit is usable one cycle later.
  assign out_valid = ~fifo_empty & (inflight_q < CNT_MAX);

  assign ht_cmd_in.ready  = in_ready;
  assign ht_cmd_out.valid = out_valid;
  assign ht_cmd_out.cmd   = head_cmd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (issue && !retire) begin
        inflight_q <= inflight_q + CNT_ONE;
      end else if (retire && !issue) begin
        if (inflight_q == '0) begin
          err_q <= 1'b1;
        end else begin
          inflight_q <= inflight_q - CNT_ONE;
        end
      end
    end
  end

  assign inflight_o      = inflight_q;
  assign err_underflow_o = err_q;

endmodule
